// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - widths, alu opcodes and the issue-stage record shared by the alu scheduler
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND    = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR     = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b1010;
  localparam logic [OP_W-1:0] OP_NOTA   = 4'b1011;
  localparam logic [OP_W-1:0] OP_SHR    = 4'b1100;
  localparam logic [OP_W-1:0] OP_SHL    = 4'b1101;
  localparam logic [OP_W-1:0] OP_ROTR   = 4'b1110;
  localparam logic [OP_W-1:0] OP_ROTL   = 4'b1111;
  // Undefined alu code: the alu keeps O unchanged while this is applied.
  localparam logic [OP_W-1:0] BUBBLE_OP = 4'b0111;

  typedef struct packed {
    logic v;
    logic id;
    logic legal;
  } stage_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOTA, OP_SHR, OP_SHL, OP_ROTR, OP_ROTL: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request/response handshakes of the two alu requesters
interface alu_sched_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_data;
  logic              resp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_data;
  logic              resp1_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, resp0_valid, resp0_data, resp0_err,
    input  req1_ready, resp1_valid, resp1_data, resp1_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, resp0_valid, resp0_data, resp0_err,
    output req1_ready, resp1_valid, resp1_data, resp1_err
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - shared 8-bit alu: operands captured at edge N, CTR applied at edge N+1
module alu
  import alu_pkg::*;
(
  input  logic              ck,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   ctr,
  output logic [DATA_W-1:0] o
);
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;

  // No reset by design: O is only meaningful once an issued op has reached it.
  always_ff @(posedge ck) begin
    ra <= a;
    rb <= b;
    case (ctr)
      OP_ADD:  o <= ra + rb;
      OP_SUB:  o <= ra - rb;
      OP_AND:  o <= ra & rb;
      OP_OR:   o <= ra | rb;
      OP_XOR:  o <= ra ^ rb;
      OP_NOTA: o <= ~ra;
      OP_SHR:  o <= {1'b0, ra[DATA_W-1:1]};
      OP_SHL:  o <= {ra[DATA_W-2:0], 1'b0};
      OP_ROTR: o <= {ra[0], ra[DATA_W-1:1]};
      OP_ROTL: o <= {ra[DATA_W-2:0], ra[DATA_W-1]};
      default: o <= o;
    endcase
  end
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; the pointer moves to the other side after a grant
module rr_arb2 (
  input  logic       ck,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst)          rr_ptr <= 1'b0;
    else if (|grant)  rr_ptr <= grant[0];
  end
endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - shares one alu between two requesters: arbitration, 2-stage issue, result steering
module alu_sched
  import alu_pkg::*;
(
  input  logic              ck,
  input  logic              rst,
  alu_sched_if.slave        bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctr,
  input  logic [DATA_W-1:0] alu_o,
  output logic              busy
);
  logic [1:0]      valid;
  logic [1:0]      grant;
  logic [OP_W-1:0] sel_op;
  logic            sel_legal;
  stage_t          s1;
  stage_t          s2;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .ck    (ck),
    .rst   (rst),
    .valid (valid),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Operands go out in the grant cycle; the opcode follows one edge later.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    sel_op = BUBBLE_OP;
    if (grant[0]) begin
      alu_a  = bus.req0_a;
      alu_b  = bus.req0_b;
      sel_op = bus.req0_op;
    end else if (grant[1]) begin
      alu_a  = bus.req1_a;
      alu_b  = bus.req1_b;
      sel_op = bus.req1_op;
    end
  end

  assign sel_legal = op_legal(sel_op);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      alu_ctr <= BUBBLE_OP;
    end else begin
      s1.v     <= |grant;
      s1.id    <= grant[1];
      s1.legal <= sel_legal;
      alu_ctr  <= (|grant && sel_legal) ? sel_op : BUBBLE_OP;
      s2       <= s1;
    end
  end

  assign busy = s1.v | s2.v;

  // Illegal ops took a slot but the alu saw a bubble, so their data is forced to zero.
  assign bus.resp0_valid = s2.v & ~s2.id;
  assign bus.resp1_valid = s2.v &  s2.id;
  assign bus.resp0_err   = bus.resp0_valid & ~s2.legal;
  assign bus.resp1_err   = bus.resp1_valid & ~s2.legal;
  assign bus.resp0_data  = (bus.resp0_valid && s2.legal) ? alu_o : '0;
  assign bus.resp1_data  = (bus.resp1_valid && s2.legal) ? alu_o : '0;
endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - scoreboard bench for alu_sched driving the real alu
module tb_alu_sched;
  import alu_pkg::*;

  logic       ck = 1'b0;
  logic       rst;
  logic [7:0] alu_a, alu_b, alu_o;
  logic [3:0] alu_ctr;
  logic       busy;

  always #5 ck = ~ck;

  alu_sched_if bus();

  alu_sched dut (
    .ck      (ck),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_o   (alu_o),
    .busy    (busy)
  );

  alu u_alu (
    .ck  (ck),
    .a   (alu_a),
    .b   (alu_b),
    .ctr (alu_ctr),
    .o   (alu_o)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } op_t;

  typedef struct {
    int id;
    int data;
    int err;
    int due;
  } exp_t;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   turn = 0;
  int   g;
  int   exp_busy;
  op_t  iss;
  exp_t ent;
  exp_t got;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_legal(input logic [3:0] op);
    return (op <= 4'd1) || (op >= 4'd8);
  endfunction

  function automatic int ref_result(input op_t o);
    int a, b;
    a = int'(o.a);
    b = int'(o.b);
    case (int'(o.op))
      0:  return (a + b) % 256;
      1:  return (a - b + 256) % 256;
      8:  return a & b;
      9:  return a | b;
      10: return a ^ b;
      11: return 255 - a;
      12: return a / 2;
      13: return (a * 2) % 256;
      14: return a / 2 + (a % 2) * 128;
      15: return (a * 2) % 256 + a / 128;
      default: return 0;
    endcase
  endfunction

  function automatic op_t mk(input int a, input int b, input int op);
    op_t o;
    o.a  = 8'(a);
    o.b  = 8'(b);
    o.op = 4'(op);
    return o;
  endfunction

  initial forever @(posedge ck) cyc <= cyc + 1;

  // Requesters hold their head op until it is accepted.
  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    forever begin
      @(posedge ck);
      #1;
      bus.req0_valid = pend0.size() > 0;
      bus.req0_a  = (pend0.size() > 0) ? pend0[0].a  : 8'h00;
      bus.req0_b  = (pend0.size() > 0) ? pend0[0].b  : 8'h00;
      bus.req0_op = (pend0.size() > 0) ? pend0[0].op : 4'h0;
      bus.req1_valid = pend1.size() > 0;
      bus.req1_a  = (pend1.size() > 0) ? pend1[0].a  : 8'h00;
      bus.req1_b  = (pend1.size() > 0) ? pend1[0].b  : 8'h00;
      bus.req1_op = (pend1.size() > 0) ? pend1[0].op : 4'h0;
    end
  end

  // Issue side: expected grant from turn-taking, expected result pushed on handshake.
  initial forever begin
    @(negedge ck);
    if (rst) begin
      chk("ready_in_reset", int'({bus.req1_ready, bus.req0_ready}), 0);
      turn = 0;
    end else begin
      g = -1;
      if (bus.req0_valid && bus.req1_valid) g = turn;
      else if (bus.req0_valid)              g = 0;
      else if (bus.req1_valid)              g = 1;
      chk("ready0", int'(bus.req0_ready), int'(g == 0));
      chk("ready1", int'(bus.req1_ready), int'(g == 1));
      if (g >= 0) begin
        iss = (g == 0) ? pend0.pop_front() : pend1.pop_front();
        ent.id   = g;
        ent.err  = ref_legal(iss.op) ? 0 : 1;
        ent.data = ref_legal(iss.op) ? ref_result(iss) : 0;
        ent.due  = cyc + 2;
        sb.push_back(ent);
        turn = 1 - g;
      end
    end
  end

  // Response side: pops the scoreboard whenever the DUT presents a result.
  initial forever begin
    @(negedge ck);
    if (rst) begin
      chk("resp_valid_in_reset", int'({bus.resp1_valid, bus.resp0_valid}), 0);
      chk("resp_err_in_reset", int'({bus.resp1_err, bus.resp0_err}), 0);
      chk("busy_in_reset", int'(busy), 0);
      chk("alu_ctr_in_reset", int'(alu_ctr), int'(BUBBLE_OP));
      sb.delete();
    end else begin
      exp_busy = 0;
      foreach (sb[i]) if (sb[i].due == cyc || sb[i].due == cyc + 1) exp_busy = 1;
      chk("busy", int'(busy), exp_busy);
      if (bus.resp0_valid || bus.resp1_valid) begin
        chk("single_resp", int'(bus.resp0_valid && bus.resp1_valid), 0);
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("resp_id", bus.resp1_valid ? 1 : 0, got.id);
          chk("resp_data", bus.resp1_valid ? int'(bus.resp1_data) : int'(bus.resp0_data), got.data);
          chk("resp_err", bus.resp1_valid ? int'(bus.resp1_err) : int'(bus.resp0_err), got.err);
          chk("resp_latency", cyc, got.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_resp", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && n < 200) begin
      @(negedge ck);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 1, 0);
    repeat (2) @(negedge ck);
    #1;
  endtask

  task automatic wait_issued();
    int n;
    n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0) && n < 50) begin
      @(negedge ck);
      #1;
      n++;
    end
    if (n >= 50) chk("issue_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);
    #1;

    pend0.push_back(mk(8'h05, 8'h03, OP_ADD));
    drain();

    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(8'h10, 8'h01, OP_SUB));
      pend1.push_back(mk(8'hF0, 8'h0F, OP_XOR));
    end
    drain();

    pend1.push_back(mk(8'h81, 8'h00, OP_ROTL));
    pend1.push_back(mk(8'h81, 8'h00, OP_SHR));
    drain();

    pend0.push_back(mk(8'h12, 8'h34, 4'b0100));
    pend0.push_back(mk(8'h20, 8'h22, OP_ADD));
    drain();

    pend0.push_back(mk(8'hFF, 8'h01, OP_ADD));
    drain();
    pend0.push_back(mk(8'h30, 8'h10, OP_SUB));
    pend0.push_back(mk(8'h55, 8'hAA, OP_XOR));
    wait_issued();
    @(posedge ck);
    #1 rst = 1'b1;
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;
    pend0.push_back(mk(8'h07, 8'h09, OP_ADD));
    drain();

    for (int i = 0; i < 3; i++) pend1.push_back(mk(8'h3C, 8'h00, OP_NOTA));
    wait_issued();
    pend0.push_back(mk(8'h0F, 8'hF3, OP_AND));
    pend1.push_back(mk(8'h40, 8'h00, OP_SHL));
    drain();

    for (int c = 0; c < 400; c++) begin
      if (pend0.size() < 2 && $urandom_range(0, 3) != 0)
        pend0.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 15))));
      if (pend1.size() < 2 && $urandom_range(0, 3) != 0)
        pend1.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 15))));
      @(negedge ck);
      #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
